// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the commit trace buffer.
// Holds the record kind and trace FSM encodings, plus the packed record
// layout (total width and field offsets) as functions of DW, AW and RW.
// Record layout, LSB first: reg | value | inst | addr | pc | inum | mem_re | kind
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        OTHER = 2'd0,
        REGWR = 2'd1,
        STORE = 2'd2,
        HALT  = 2'd3
    } rec_kind_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_t;

    localparam int INUM_W = 32;
    localparam int KIND_W = 2;

    function automatic int rec_w(input int dw, input int aw, input int rw);
        return KIND_W + 1 + INUM_W + 2 * aw + 2 * dw + rw;
    endfunction

    function automatic int off_reg();
        return 0;
    endfunction

    function automatic int off_value(input int rw);
        return rw;
    endfunction

    function automatic int off_inst(input int dw, input int rw);
        return rw + dw;
    endfunction

    function automatic int off_addr(input int dw, input int rw);
        return rw + 2 * dw;
    endfunction

    function automatic int off_pc(input int dw, input int aw, input int rw);
        return rw + 2 * dw + aw;
    endfunction

    function automatic int off_inum(input int dw, input int aw, input int rw);
        return rw + 2 * dw + 2 * aw;
    endfunction

    function automatic int off_mem_re(input int dw, input int aw, input int rw);
        return rw + 2 * dw + 2 * aw + INUM_W;
    endfunction

    function automatic int off_kind(input int dw, input int aw, input int rw);
        return rw + 2 * dw + 2 * aw + INUM_W + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head-of-queue output.
// Ports: clk, rst_n (sync, active-low); push/push_data write an entry,
// pop removes the head; pop_data is the current head (registered);
// full/empty are registered flags derived from pointers with an extra wrap bit.
// A push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW:0]      wptr_r;
    logic [PW:0]      rptr_r;
    logic [PW:0]      wptr_nxt_s;
    logic [PW:0]      rptr_nxt_s;
    logic             do_push_s;
    logic             do_pop_s;
    logic [WIDTH-1:0] head_s;

    // Next-pointer computation and the value the head register will hold next.
    always_comb begin
        do_pop_s   = pop & ~empty;
        do_push_s  = push & (~full | do_pop_s);
        wptr_nxt_s = do_push_s ? (wptr_r + {{PW{1'b0}}, 1'b1}) : wptr_r;
        rptr_nxt_s = do_pop_s  ? (rptr_r + {{PW{1'b0}}, 1'b1}) : rptr_r;
        // The next head may be the entry being written this very cycle.
        if (do_push_s && (wptr_r[PW-1:0] == rptr_nxt_s[PW-1:0])) begin
            head_s = push_data;
        end else begin
            head_s = mem_r[rptr_nxt_s[PW-1:0]];
        end
    end

    // Storage array write port (contents need no reset).
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r[PW-1:0]] <= push_data;
        end
    end

    // Pointers, status flags and registered head output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_r   <= '0;
            rptr_r   <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            pop_data <= '0;
        end else begin
            wptr_r <= wptr_nxt_s;
            rptr_r <= rptr_nxt_s;
            empty  <= (wptr_nxt_s == rptr_nxt_s);
            full   <= (wptr_nxt_s[PW] != rptr_nxt_s[PW]) &&
                      (wptr_nxt_s[PW-1:0] == rptr_nxt_s[PW-1:0]);
            // Hold the last head when going empty so the output never glitches.
            if (wptr_nxt_s != rptr_nxt_s) begin
                pop_data <= head_s;
            end
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement monitor tapped at the writeback stage of the 16-bit CPU.
// Ports: clk, rst_n (sync, active-low); commit_* describe the retiring
// instruction; rec_valid/rec_ready/rec_data stream packed trace records;
// inst_count/cycle_count are saturating counters; overflow/timeout are sticky;
// done is set once the run has ended and every record has been drained.
module commit_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int DW          = 16,
    parameter int AW          = 16,
    parameter int RW          = 4,
    parameter int DEPTH       = 16,
    parameter int CYCLE_LIMIT = 100000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        commit_valid,
    input  logic [AW-1:0]               commit_pc,
    input  logic [DW-1:0]               commit_inst,
    input  logic                        commit_reg_we,
    input  logic [RW-1:0]               commit_reg,
    input  logic [DW-1:0]               commit_reg_data,
    input  logic                        commit_mem_re,
    input  logic                        commit_mem_we,
    input  logic [AW-1:0]               commit_mem_addr,
    input  logic [DW-1:0]               commit_mem_data,
    input  logic                        commit_halt,
    output logic                        rec_valid,
    input  logic                        rec_ready,
    output logic [rec_w(DW, AW, RW)-1:0] rec_data,
    output logic [31:0]                 inst_count,
    output logic [31:0]                 cycle_count,
    output logic                        overflow,
    output logic                        timeout,
    output logic                        done
);

    localparam int REC_W    = rec_w(DW, AW, RW);
    localparam int O_REG    = off_reg();
    localparam int O_VALUE  = off_value(RW);
    localparam int O_INST   = off_inst(DW, RW);
    localparam int O_ADDR   = off_addr(DW, RW);
    localparam int O_PC     = off_pc(DW, AW, RW);
    localparam int O_INUM   = off_inum(DW, AW, RW);
    localparam int O_MEM_RE = off_mem_re(DW, AW, RW);
    localparam int O_KIND   = off_kind(DW, AW, RW);

    // Timeout fires on the edge where cycle_count becomes CYCLE_LIMIT.
    localparam logic [31:0] LIMIT_M1 = 32'(CYCLE_LIMIT - 1);
    localparam logic [31:0] SAT      = 32'hFFFF_FFFF;

    trace_state_t     state_r;
    rec_kind_t        kind_s;
    logic [REC_W-1:0] rec_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    // Classify the retiring instruction and pack its trace record.
    always_comb begin
        if (commit_halt) begin
            kind_s = HALT;
        end else if (commit_mem_we) begin
            kind_s = STORE;
        end else if (commit_reg_we) begin
            kind_s = REGWR;
        end else begin
            kind_s = OTHER;
        end
        rec_s                      = '0;
        rec_s[O_REG +: RW]         = commit_reg;
        rec_s[O_VALUE +: DW]       = (kind_s == STORE) ? commit_mem_data : commit_reg_data;
        rec_s[O_INST +: DW]        = commit_inst;
        rec_s[O_ADDR +: AW]        = commit_mem_addr;
        rec_s[O_PC +: AW]          = commit_pc;
        rec_s[O_INUM +: INUM_W]    = inst_count;
        rec_s[O_MEM_RE]            = commit_mem_re & commit_reg_we;
        rec_s[O_KIND +: KIND_W]    = kind_s;
    end

    assign rec_valid = ~fifo_empty_s;
    assign push_s    = commit_valid & (state_r == ST_RUN);
    assign pop_s     = rec_valid & rec_ready;
    assign drop_s    = push_s & fifo_full_s & ~pop_s;

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (rec_s),
        .pop       (pop_s),
        .pop_data  (rec_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Trace FSM with its counters and sticky status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            inst_count  <= 32'd0;
            cycle_count <= 32'd0;
            overflow    <= 1'b0;
            timeout     <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (cycle_count != SAT) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                    // Dropped records still consume an instruction number.
                    if (commit_valid && (inst_count != SAT)) begin
                        inst_count <= inst_count + 32'd1;
                    end
                    if (drop_s) begin
                        overflow <= 1'b1;
                    end
                    if (commit_valid && commit_halt) begin
                        state_r <= ST_DRAIN;
                    end else if (cycle_count >= LIMIT_M1) begin
                        state_r <= ST_TIMEOUT;
                        timeout <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN, ST_TIMEOUT: begin
                    if (fifo_empty_s && !pop_s) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer (DEPTH=16, CYCLE_LIMIT=50).
// Record layout, LSB first: reg[3:0] value[19:4] inst[35:20] addr[51:36]
// pc[67:52] inum[99:68] mem_re[100] kind[102:101].
module tb_commit_trace_buffer;

    localparam int DW          = 16;
    localparam int AW          = 16;
    localparam int RW          = 4;
    localparam int DEPTH       = 16;
    localparam int CYCLE_LIMIT = 50;
    localparam int REC_W       = 3 + 32 + 2 * AW + 2 * DW + RW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             commit_valid;
    logic [AW-1:0]    commit_pc;
    logic [DW-1:0]    commit_inst;
    logic             commit_reg_we;
    logic [RW-1:0]    commit_reg;
    logic [DW-1:0]    commit_reg_data;
    logic             commit_mem_re;
    logic             commit_mem_we;
    logic [AW-1:0]    commit_mem_addr;
    logic [DW-1:0]    commit_mem_data;
    logic             commit_halt;
    logic             rec_valid;
    logic             rec_ready;
    logic [REC_W-1:0] rec_data;
    logic [31:0]      inst_count;
    logic [31:0]      cycle_count;
    logic             overflow;
    logic             timeout;
    logic             done;

    int checks = 0;
    int errors = 0;

    commit_trace_buffer #(
        .DW (DW), .AW (AW), .RW (RW), .DEPTH (DEPTH), .CYCLE_LIMIT (CYCLE_LIMIT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .commit_inst     (commit_inst),
        .commit_reg_we   (commit_reg_we),
        .commit_reg      (commit_reg),
        .commit_reg_data (commit_reg_data),
        .commit_mem_re   (commit_mem_re),
        .commit_mem_we   (commit_mem_we),
        .commit_mem_addr (commit_mem_addr),
        .commit_mem_data (commit_mem_data),
        .commit_halt     (commit_halt),
        .rec_valid       (rec_valid),
        .rec_ready       (rec_ready),
        .rec_data        (rec_data),
        .inst_count      (inst_count),
        .cycle_count     (cycle_count),
        .overflow        (overflow),
        .timeout         (timeout),
        .done            (done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0]  f_reg(input logic [REC_W-1:0] r);    return r[3:0];     endfunction
    function automatic logic [15:0] f_value(input logic [REC_W-1:0] r);  return r[19:4];    endfunction
    function automatic logic [15:0] f_inst(input logic [REC_W-1:0] r);   return r[35:20];   endfunction
    function automatic logic [15:0] f_addr(input logic [REC_W-1:0] r);   return r[51:36];   endfunction
    function automatic logic [15:0] f_pc(input logic [REC_W-1:0] r);     return r[67:52];   endfunction
    function automatic logic [31:0] f_inum(input logic [REC_W-1:0] r);   return r[99:68];   endfunction
    function automatic logic        f_mem_re(input logic [REC_W-1:0] r); return r[100];     endfunction
    function automatic logic [1:0]  f_kind(input logic [REC_W-1:0] r);   return r[102:101]; endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        commit_valid    = 1'b0;
        commit_pc       = 16'h0000;
        commit_inst     = 16'h0000;
        commit_reg_we   = 1'b0;
        commit_reg      = 4'h0;
        commit_reg_data = 16'h0000;
        commit_mem_re   = 1'b0;
        commit_mem_we   = 1'b0;
        commit_mem_addr = 16'h0000;
        commit_mem_data = 16'h0000;
        commit_halt     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rec_ready = 1'b0;
        do_reset();
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", rec_valid); end
        checks++; if (rec_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", rec_data); end
        checks++; if (inst_count !== 32'd0) begin errors++; $display("FAIL reset_inst_count got %0d want 0", inst_count); end
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle_count got %0d want 0", cycle_count); end
        checks++; if ({overflow, timeout, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {overflow, timeout, done}); end
    endtask

    task automatic test_add();
        do_reset();
        rec_ready       = 1'b1;
        commit_valid    = 1'b1;
        commit_pc       = 16'h0000;
        commit_inst     = 16'h1123;
        commit_reg_we   = 1'b1;
        commit_reg      = 4'd1;
        commit_reg_data = 16'h0005;
        tick();
        idle_inputs();
        checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b want 1", rec_valid); end
        checks++; if (f_kind(rec_data) !== 2'd1) begin errors++; $display("FAIL add_kind got %0d want 1", f_kind(rec_data)); end
        checks++; if (f_inum(rec_data) !== 32'd0) begin errors++; $display("FAIL add_inum got %0d want 0", f_inum(rec_data)); end
        checks++; if (f_reg(rec_data) !== 4'd1) begin errors++; $display("FAIL add_reg got %0d want 1", f_reg(rec_data)); end
        checks++; if (f_value(rec_data) !== 16'h0005) begin errors++; $display("FAIL add_value got %h want 0005", f_value(rec_data)); end
        checks++; if (f_inst(rec_data) !== 16'h1123) begin errors++; $display("FAIL add_inst got %h want 1123", f_inst(rec_data)); end
        checks++; if (f_mem_re(rec_data) !== 1'b0) begin errors++; $display("FAIL add_mem_re got %0b want 0", f_mem_re(rec_data)); end
        checks++; if (inst_count !== 32'd1) begin errors++; $display("FAIL add_inst_count got %0d want 1", inst_count); end
        tick();
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL add_popped got %0b want 0", rec_valid); end
    endtask

    task automatic test_load_store();
        do_reset();
        rec_ready       = 1'b1;
        commit_valid    = 1'b1;
        commit_pc       = 16'h0002;
        commit_reg_we   = 1'b1;
        commit_reg      = 4'd2;
        commit_mem_re   = 1'b1;
        commit_mem_addr = 16'h0040;
        commit_reg_data = 16'hBEEF;
        tick();
        idle_inputs();
        commit_valid    = 1'b1;
        commit_pc       = 16'h0004;
        commit_mem_we   = 1'b1;
        commit_mem_addr = 16'h0042;
        commit_mem_data = 16'h1234;
        checks++; if (f_kind(rec_data) !== 2'd1 || f_mem_re(rec_data) !== 1'b1) begin errors++; $display("FAIL load_kind got kind=%0d mem_re=%0b want 1/1", f_kind(rec_data), f_mem_re(rec_data)); end
        checks++; if (f_addr(rec_data) !== 16'h0040) begin errors++; $display("FAIL load_addr got %h want 0040", f_addr(rec_data)); end
        checks++; if (f_value(rec_data) !== 16'hBEEF) begin errors++; $display("FAIL load_value got %h want beef", f_value(rec_data)); end
        tick();
        idle_inputs();
        checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL store_valid got %0b want 1", rec_valid); end
        checks++; if (f_kind(rec_data) !== 2'd2 || f_mem_re(rec_data) !== 1'b0) begin errors++; $display("FAIL store_kind got kind=%0d mem_re=%0b want 2/0", f_kind(rec_data), f_mem_re(rec_data)); end
        checks++; if (f_value(rec_data) !== 16'h1234) begin errors++; $display("FAIL store_value got %h want 1234", f_value(rec_data)); end
        checks++; if (f_inum(rec_data) !== 32'd1) begin errors++; $display("FAIL store_inum got %0d want 1", f_inum(rec_data)); end
        checks++; if (f_addr(rec_data) !== 16'h0042 || f_pc(rec_data) !== 16'h0004) begin errors++; $display("FAIL store_addr_pc got %h/%h want 0042/0004", f_addr(rec_data), f_pc(rec_data)); end
        tick();
        checks++; if (rec_valid !== 1'b0 || inst_count !== 32'd2) begin errors++; $display("FAIL ls_end got valid=%0b count=%0d want 0/2", rec_valid, inst_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            commit_valid    = 1'b1;
            commit_reg_we   = 1'b1;
            commit_reg      = 4'(i);
            commit_reg_data = 16'(i);
            commit_pc       = 16'(2 * i);
            tick();
            if (i == 15) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full got %0b want 0", overflow); end
            end
            if (i == 16) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_first_drop got %0b want 1", overflow); end
            end
        end
        checks++; if (inst_count !== 32'd20) begin errors++; $display("FAIL ovf_inst_count got %0d want 20", inst_count); end
        checks++; if (f_inum(rec_data) !== 32'd0 || rec_valid !== 1'b1) begin errors++; $display("FAIL ovf_head got inum=%0d valid=%0b want 0/1", f_inum(rec_data), rec_valid); end
        // Push with simultaneous pop while full: both must succeed.
        commit_reg_data = 16'd20;
        commit_reg      = 4'd4;
        rec_ready       = 1'b1;
        tick();
        idle_inputs();
        checks++; if (inst_count !== 32'd21) begin errors++; $display("FAIL full_pushpop_count got %0d want 21", inst_count); end
        for (int i = 1; i < 16; i++) begin
            checks++; if (f_inum(rec_data) !== 32'(i) || f_value(rec_data) !== 16'(i)) begin errors++; $display("FAIL ovf_order got inum=%0d value=%0d want %0d", f_inum(rec_data), f_value(rec_data), i); end
            tick();
        end
        checks++; if (rec_valid !== 1'b1 || f_inum(rec_data) !== 32'd20) begin errors++; $display("FAIL full_pushpop_rec got valid=%0b inum=%0d want 1/20", rec_valid, f_inum(rec_data)); end
        tick();
        checks++; if (rec_valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_drained got valid=%0b ovf=%0b want 0/1", rec_valid, overflow); end
    endtask

    task automatic test_halt();
        do_reset();
        rec_ready    = 1'b1;
        commit_valid = 1'b1;
        commit_pc    = 16'h0000;
        tick();
        idle_inputs();
        checks++; if (f_kind(rec_data) !== 2'd0 || f_inum(rec_data) !== 32'd0) begin errors++; $display("FAIL halt_c0 got kind=%0d inum=%0d want 0/0", f_kind(rec_data), f_inum(rec_data)); end
        commit_valid    = 1'b1;
        commit_pc       = 16'h0002;
        commit_reg_we   = 1'b1;
        commit_reg      = 4'd3;
        commit_reg_data = 16'h0033;
        tick();
        idle_inputs();
        checks++; if (f_kind(rec_data) !== 2'd1 || f_inum(rec_data) !== 32'd1 || f_value(rec_data) !== 16'h0033) begin errors++; $display("FAIL halt_c1 got kind=%0d inum=%0d value=%h want 1/1/0033", f_kind(rec_data), f_inum(rec_data), f_value(rec_data)); end
        commit_valid    = 1'b1;
        commit_pc       = 16'h0004;
        commit_mem_we   = 1'b1;
        commit_mem_addr = 16'h0100;
        commit_mem_data = 16'hAAAA;
        tick();
        idle_inputs();
        checks++; if (f_kind(rec_data) !== 2'd2 || f_inum(rec_data) !== 32'd2 || f_value(rec_data) !== 16'hAAAA) begin errors++; $display("FAIL halt_c2 got kind=%0d inum=%0d value=%h want 2/2/aaaa", f_kind(rec_data), f_inum(rec_data), f_value(rec_data)); end
        commit_valid = 1'b1;
        commit_pc    = 16'h0010;
        commit_inst  = 16'hF000;
        commit_halt  = 1'b1;
        tick();
        // Junk commits held after the halt must be ignored.
        idle_inputs();
        commit_valid  = 1'b1;
        commit_reg_we = 1'b1;
        checks++; if (f_kind(rec_data) !== 2'd3 || f_inum(rec_data) !== 32'd3 || f_pc(rec_data) !== 16'h0010) begin errors++; $display("FAIL halt_rec got kind=%0d inum=%0d pc=%h want 3/3/0010", f_kind(rec_data), f_inum(rec_data), f_pc(rec_data)); end
        for (int k = 0; k < 6 && done !== 1'b1; k++) tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_done got %0b want 1", done); end
        checks++; if (rec_valid !== 1'b0 || inst_count !== 32'd4) begin errors++; $display("FAIL halt_ignored got valid=%0b count=%0d want 0/4", rec_valid, inst_count); end
        checks++; if (cycle_count !== 32'd4 || timeout !== 1'b0) begin errors++; $display("FAIL halt_frozen got cycles=%0d timeout=%0b want 4/0", cycle_count, timeout); end
        idle_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        rec_ready = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            idle_inputs();
            if (n <= 2 || n == 50) begin
                commit_valid    = 1'b1;
                commit_reg_we   = 1'b1;
                commit_reg_data = 16'(n);
                commit_pc       = 16'(2 * n);
            end
            tick();
            if (n == 49) begin
                checks++; if (timeout !== 1'b0 || cycle_count !== 32'd49) begin errors++; $display("FAIL to_before got timeout=%0b cycles=%0d want 0/49", timeout, cycle_count); end
            end
        end
        checks++; if (timeout !== 1'b1 || cycle_count !== 32'd50) begin errors++; $display("FAIL to_fire got timeout=%0b cycles=%0d want 1/50", timeout, cycle_count); end
        checks++; if (inst_count !== 32'd3) begin errors++; $display("FAIL to_last_commit got %0d want 3", inst_count); end
        tick();
        idle_inputs();
        checks++; if (inst_count !== 32'd3 || cycle_count !== 32'd50) begin errors++; $display("FAIL to_frozen got count=%0d cycles=%0d want 3/50", inst_count, cycle_count); end
        rec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rec_valid !== 1'b1 || f_inum(rec_data) !== 32'(i)) begin errors++; $display("FAIL to_drain got valid=%0b inum=%0d want 1/%0d", rec_valid, f_inum(rec_data), i); end
            tick();
        end
        for (int k = 0; k < 6 && done !== 1'b1; k++) tick();
        checks++; if (done !== 1'b1 || rec_valid !== 1'b0 || timeout !== 1'b1) begin errors++; $display("FAIL to_done got done=%0b valid=%0b timeout=%0b want 1/0/1", done, rec_valid, timeout); end
    endtask

    task automatic test_midrun_reset();
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            commit_valid    = 1'b1;
            commit_reg_we   = 1'b1;
            commit_reg_data = 16'(i + 100);
            tick();
        end
        checks++; if (rec_valid !== 1'b1 || inst_count !== 32'd5) begin errors++; $display("FAIL mr_before got valid=%0b count=%0d want 1/5", rec_valid, inst_count); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle_inputs();
        checks++; if (rec_valid !== 1'b0 || rec_data !== '0) begin errors++; $display("FAIL mr_flush got valid=%0b data=%h want 0/0", rec_valid, rec_data); end
        checks++; if (inst_count !== 32'd0 || cycle_count !== 32'd0) begin errors++; $display("FAIL mr_counters got %0d/%0d want 0/0", inst_count, cycle_count); end
        checks++; if ({overflow, timeout, done} !== 3'b000) begin errors++; $display("FAIL mr_flags got %b want 000", {overflow, timeout, done}); end
        tick();
        checks++; if (rec_valid !== 1'b0 || cycle_count !== 32'd1) begin errors++; $display("FAIL mr_after got valid=%0b cycles=%0d want 0/1", rec_valid, cycle_count); end
    endtask

    initial begin
        rst_n     = 1'b0;
        rec_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_add();
        test_load_store();
        test_overflow();
        test_halt();
        test_timeout();
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
